// File: rtl/rv32i_pkg.sv
// Shared definitions for the multi-cycle RV32I control path:
// opcode constants, FSM state encoding and datapath select encodings.
package rv32i_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JAL    = 2'b10,
    NPC_JALR   = 2'b11
  } next_pc_e;

  // True for the opcodes this control path knows how to sequence.
  function automatic logic opcode_known(input logic [OPCODE_W-1:0] op);
    logic known;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: known = 1'b1;
      default:                                                   known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/rv32i_mc_ctrlpath_if.sv
// Instruction/data memory handshake bundle for the multi-cycle control path.
//   imem_req / imem_ack                 : instruction fetch request / word valid
//   dmem_req / dmem_ack                 : data access request / access complete
//   data_mem_read_enable / _write_enable: load / store qualifier for dmem_req
// master = control path, slave = memory side.
interface rv32i_mc_ctrlpath_if;

  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic data_mem_read_enable;
  logic data_mem_write_enable;

  modport master (
    output imem_req,
    output dmem_req,
    output data_mem_read_enable,
    output data_mem_write_enable,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  data_mem_read_enable,
    input  data_mem_write_enable,
    output imem_ack,
    output dmem_ack
  );

endinterface

// File: rtl/rv32i_branch_cond.sv
// Branch condition evaluation from ALU flags.
//   funct3  in : branch type
//   zero/lt/ltu in : ALU flags (equal, signed less, unsigned less)
//   taken   out: branch condition holds
//   illegal out: funct3 is not a supported branch
// Macro RV32I_CTRL_FULL_BRANCH_EN adds BLT/BGE/BLTU/BGEU; otherwise only
// BEQ/BNE are legal.
module rv32i_branch_cond
  import rv32i_pkg::*;
(
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  output logic                taken,
  output logic                illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000: taken = zero;
      3'b001: taken = !zero;
`ifdef RV32I_CTRL_FULL_BRANCH_EN
      3'b100: taken = lt;
      3'b101: taken = !lt;
      3'b110: taken = ltu;
      3'b111: taken = !ltu;
`endif
      default: illegal = 1'b1;
    endcase
  end

`ifndef RV32I_CTRL_FULL_BRANCH_EN
  // Ordering flags are only consumed by the full branch set.
  logic unused_flags;
  assign unused_flags = lt ^ ltu;
`endif

endmodule

// File: rtl/rv32i_mc_ctrlpath.sv
// Multi-cycle RV32I control path: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// the shared datapath (PC, IR, regfile, ALU muxes, memory enables), with
// req/ack memory handshakes, branch resolution and sticky trap flags.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   bus (master)               imem/dmem req/ack and data read/write enables
//   inst_opcode/funct3/funct7  IR fields (funct7 passes through to the ALU)
//   alu_zero/lt/ltu            ALU flags for branch evaluation
//   *_write_enable, *_select   datapath controls
//   alu_op_type                00 add, 01 sub, 10 R funct, 11 I funct
//   illegal_inst, mem_timeout  sticky trap causes, cleared only by rst_n
// Parameters: MEM_TIMEOUT (0 disables), TO_CNT_W (MEM_TIMEOUT < 2**TO_CNT_W).
// Macro RV32I_CTRL_FULL_BRANCH_EN enables BLT/BGE/BLTU/BGEU.
module rv32i_mc_ctrlpath
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32i_mc_ctrlpath_if.master   bus,
  input  logic [OPCODE_W-1:0]   inst_opcode,
  input  logic [FUNCT3_W-1:0]   inst_funct3,
  input  logic [6:0]            inst_funct7,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  output logic                  ir_write_enable,
  output logic                  pc_write_enable,
  output logic                  regfile_write_enable,
  output logic                  alu_operand_a_select,
  output logic                  alu_operand_b_select,
  output logic [1:0]            reg_writeback_select,
  output logic [1:0]            alu_op_type,
  output logic [1:0]            next_pc_select,
  output logic                  illegal_inst,
  output logic                  mem_timeout
);

  // Last count value before the timeout fires.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MEM_TIMEOUT - 1);

  state_e               state, state_next;
  logic                 run;
  logic [TO_CNT_W-1:0]  to_cnt, to_cnt_next;
  logic                 illegal_next, timeout_next;
  logic                 waiting;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [FUNCT3_W-1:0]  funct3_q;
  logic [FUNCT3_W-1:0]  br_funct3;
  logic                 br_taken, br_illegal;
  logic                 imem_req_c, dmem_req_c, rd_en_c, wr_en_c;

  // funct7 is decoded by the ALU, not here.
  logic unused_funct7;
  assign unused_funct7 = ^inst_funct7;

  assign bus.imem_req              = imem_req_c;
  assign bus.dmem_req              = dmem_req_c;
  assign bus.data_mem_read_enable  = rd_en_c;
  assign bus.data_mem_write_enable = wr_en_c;

  // DECODE checks the live funct3; EXEC resolves with the latched copy.
  assign br_funct3 = (state == S_DECODE) ? inst_funct3 : funct3_q;

  rv32i_branch_cond u_branch_cond (
    .funct3  (br_funct3),
    .zero    (alu_zero),
    .lt      (alu_lt),
    .ltu     (alu_ltu),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  // State, timeout counter and sticky trap flags.
  // run holds all outputs low in the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      run          <= 1'b0;
      to_cnt       <= '0;
      illegal_inst <= 1'b0;
      mem_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      run          <= 1'b1;
      to_cnt       <= to_cnt_next;
      illegal_inst <= illegal_next;
      mem_timeout  <= timeout_next;
    end
  end

  // Instruction fields captured in DECODE for use in later states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      funct3_q <= '0;
    end else if (state == S_DECODE) begin
      opcode_q <= inst_opcode;
      funct3_q <= inst_funct3;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next           = state;
    illegal_next         = illegal_inst;
    timeout_next         = mem_timeout;
    to_cnt_next          = '0;
    waiting              = 1'b0;
    imem_req_c           = 1'b0;
    dmem_req_c           = 1'b0;
    rd_en_c              = 1'b0;
    wr_en_c              = 1'b0;
    ir_write_enable      = 1'b0;
    pc_write_enable      = 1'b0;
    regfile_write_enable = 1'b0;
    alu_operand_a_select = 1'b0;
    alu_operand_b_select = 1'b0;
    reg_writeback_select = WB_ALU;
    alu_op_type          = ALU_ADD;
    next_pc_select       = NPC_PLUS4;

    case (state)
      S_FETCH: begin
        if (run) begin
          imem_req_c = 1'b1;
          if (bus.imem_ack) begin
            ir_write_enable = 1'b1;
            state_next      = S_DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
      end

      S_DECODE: begin
        if (!opcode_known(inst_opcode) ||
            ((inst_opcode == OP_BRANCH) && br_illegal)) begin
          state_next   = S_TRAP;
          illegal_next = 1'b1;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        state_next = S_WB;
        case (opcode_q)
          OP_R: alu_op_type = ALU_RFUNCT;
          OP_I: begin
            alu_op_type          = ALU_IFUNCT;
            alu_operand_b_select = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            alu_operand_b_select = 1'b1;
            state_next           = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_type     = ALU_SUB;
            pc_write_enable = 1'b1;
            next_pc_select  = br_taken ? NPC_BRANCH : NPC_PLUS4;
            state_next      = S_FETCH;
          end
          OP_JAL: begin
            alu_operand_a_select = 1'b1;
            alu_operand_b_select = 1'b1;
          end
          OP_JALR: alu_operand_b_select = 1'b1;
          default: begin
            state_next   = S_TRAP;
            illegal_next = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        rd_en_c    = (opcode_q == OP_LOAD);
        wr_en_c    = (opcode_q == OP_STORE);
        if (bus.dmem_ack) begin
          if (opcode_q == OP_LOAD) begin
            state_next = S_WB;
          end else begin
            pc_write_enable = 1'b1;
            state_next      = S_FETCH;
          end
        end else begin
          waiting = 1'b1;
        end
      end

      S_WB: begin
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        state_next           = S_FETCH;
        case (opcode_q)
          OP_LOAD: reg_writeback_select = WB_MEM;
          OP_JAL: begin
            reg_writeback_select = WB_PC4;
            next_pc_select       = NPC_JAL;
          end
          OP_JALR: begin
            reg_writeback_select = WB_PC4;
            next_pc_select       = NPC_JALR;
          end
          default: ;
        endcase
      end

      S_TRAP: ;

      default: state_next = S_TRAP;
    endcase

    // Ack-wait timeout: counts unacknowledged FETCH/MEM cycles.
    if (waiting && (MEM_TIMEOUT != 0)) begin
      if (to_cnt == TO_LAST) begin
        state_next   = S_TRAP;
        timeout_next = 1'b1;
      end else begin
        to_cnt_next = to_cnt + TO_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrlpath.sv
// Self-checking bench for rv32i_mc_ctrlpath: per-cycle expected control
// vectors are queued with their stimulus and compared as the DUT runs.
module tb_rv32i_mc_ctrlpath;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic       a_sel;
    logic       b_sel;
    logic       rd_en;
    logic       wr_en;
    logic [1:0] wb_sel;
    logic [1:0] alu_op;
    logic [1:0] npc;
    logic       illegal;
    logic       timeout;
  } ctrl_t;

  typedef struct packed {
    logic iack;
    logic dack;
    logic zero;
    logic lt;
  } stim_t;

  localparam ctrl_t IDLE = '0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] inst_opcode = '0;
  logic [2:0] inst_funct3 = '0;
  logic [6:0] inst_funct7 = '0;
  logic       alu_zero = 1'b0;
  logic       alu_lt = 1'b0;
  logic       alu_ltu = 1'b0;
  logic       ir_write_enable, pc_write_enable, regfile_write_enable;
  logic       alu_operand_a_select, alu_operand_b_select;
  logic [1:0] reg_writeback_select, alu_op_type, next_pc_select;
  logic       illegal_inst, mem_timeout;

  int checks = 0;
  int failures = 0;

  ctrl_t exp_q[$];
  stim_t stim_q[$];

  rv32i_mc_ctrlpath_if mem_if ();

  rv32i_mc_ctrlpath #(.MEM_TIMEOUT(4), .TO_CNT_W(3)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (mem_if),
    .inst_opcode          (inst_opcode),
    .inst_funct3          (inst_funct3),
    .inst_funct7          (inst_funct7),
    .alu_zero             (alu_zero),
    .alu_lt               (alu_lt),
    .alu_ltu              (alu_ltu),
    .ir_write_enable      (ir_write_enable),
    .pc_write_enable      (pc_write_enable),
    .regfile_write_enable (regfile_write_enable),
    .alu_operand_a_select (alu_operand_a_select),
    .alu_operand_b_select (alu_operand_b_select),
    .reg_writeback_select (reg_writeback_select),
    .alu_op_type          (alu_op_type),
    .next_pc_select       (next_pc_select),
    .illegal_inst         (illegal_inst),
    .mem_timeout          (mem_timeout)
  );

  always #5 clk = ~clk;

  // Field order: ireq dreq ir_we pc_we rf_we a b rd wr wb op npc ill to
  function automatic ctrl_t c(input bit ireq, input bit dreq, input bit irw,
                              input bit pcw, input bit rfw, input bit as,
                              input bit bs, input bit rd, input bit wr,
                              input bit [1:0] wb, input bit [1:0] op,
                              input bit [1:0] np, input bit ill, input bit to);
    ctrl_t r;
    r = '{ireq, dreq, irw, pcw, rfw, as, bs, rd, wr, wb, op, np, ill, to};
    return r;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t r;
    r = '{mem_if.imem_req, mem_if.dmem_req, ir_write_enable, pc_write_enable,
          regfile_write_enable, alu_operand_a_select, alu_operand_b_select,
          mem_if.data_mem_read_enable, mem_if.data_mem_write_enable,
          reg_writeback_select, alu_op_type, next_pc_select,
          illegal_inst, mem_timeout};
    return r;
  endfunction

  task automatic push(input bit iack, input bit dack, input bit z,
                      input bit lt, input ctrl_t e);
    stim_t s;
    s = '{iack, dack, z, lt};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    mem_if.imem_ack = s.iack;
    mem_if.dmem_ack = s.dack;
    alu_zero        = s.zero;
    alu_lt          = s.lt;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push_fetch_decode();
    push(1, 0, 0, 0, c(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    push(1, 0, 0, 0, IDLE);
  endtask

  task automatic test_reset();
    ctrl_t got;
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = sample();
    checks++;
    if (got !== IDLE) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", got, IDLE);
    end
    release_reset();
  endtask

  task automatic test_alu();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    // ADD, zero-wait ack: 4 cycles, ack held high throughout
    inst_opcode = 7'b0110011; inst_funct3 = 3'b000;
    push_fetch_decode();
    push(1, 1, 0, 0, c(0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0,0));
    push(1, 1, 0, 0, c(0,0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL add cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    // ADDI with three unacknowledged fetch cycles (one short of timeout)
    cyc = 0;
    inst_opcode = 7'b0010011;
    repeat (3) push(0, 0, 0, 0, c(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,2'b00,2'b11,2'b00,0,0));
    push(0, 0, 0, 0, c(0,0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL addi_wait cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_load_store();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    // LW with 3 dmem wait cycles: 8 cycles total
    inst_opcode = 7'b0000011; inst_funct3 = 3'b010;
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0));
    repeat (3) push(0, 0, 0, 0, c(0,1,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0));
    push(0, 1, 0, 0, c(0,1,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0));
    push(0, 0, 0, 0, c(0,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    // SW, zero-wait: 4 cycles, PC updated on the ack cycle
    inst_opcode = 7'b0000011;
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL lw cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    cyc = 0;
    inst_opcode = 7'b0100011;
    push_fetch_decode();
    push(1, 1, 0, 0, c(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0));
    push(1, 1, 0, 0, c(0,1,0,1,0,0,0,0,1,2'b00,2'b00,2'b00,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL sw cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_branch();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    // BEQ taken, BEQ not taken, BNE taken: 3 cycles each, back to back
    inst_opcode = 7'b1100011; inst_funct3 = 3'b000;
    push_fetch_decode();
    push(0, 0, 1, 0, c(0,0,0,1,0,0,0,0,0,2'b00,2'b01,2'b01,0,0));
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL beq cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    cyc = 0;
    inst_funct3 = 3'b001;
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,1,0,0,0,0,0,2'b00,2'b01,2'b01,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL bne cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_jump();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    inst_opcode = 7'b1101111; inst_funct3 = 3'b000;
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0));
    push(0, 0, 0, 0, c(0,0,0,1,1,0,0,0,0,2'b10,2'b00,2'b10,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL jal cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    cyc = 0;
    inst_opcode = 7'b1100111;
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0));
    push(0, 0, 0, 0, c(0,0,0,1,1,0,0,0,0,2'b10,2'b00,2'b11,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL jalr cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
  endtask

  task automatic test_async_abort();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    // Reset asserted mid-cycle while a load waits in MEM
    inst_opcode = 7'b0000011; inst_funct3 = 3'b010;
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0));
    push(0, 0, 0, 0, c(0,1,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL abort_pre cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    #1 rst_n = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== IDLE) begin
      failures++;
      $display("FAIL abort got=%b exp=%b", got, IDLE);
    end
    release_reset();
  endtask

  task automatic test_illegal();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    // Unknown opcode: TRAP after DECODE, sticky, no further fetches
    inst_opcode = 7'h7F; inst_funct3 = 3'b000;
    push_fetch_decode();
    repeat (3) push(1, 1, 0, 0, c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0));
    // Branch funct3 010 is never legal
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL illegal_op cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== IDLE) begin
      failures++;
      $display("FAIL illegal_clear got=%b exp=%b", got, IDLE);
    end
    release_reset();
    cyc = 0;
    inst_opcode = 7'b1100011; inst_funct3 = 3'b010;
    push_fetch_decode();
    push(1, 0, 1, 0, c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL illegal_f3 cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    rst_n = 1'b0;
    release_reset();
  endtask

  task automatic test_blt();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    inst_opcode = 7'b1100011; inst_funct3 = 3'b100;
    push_fetch_decode();
`ifdef RV32I_CTRL_FULL_BRANCH_EN
    push(0, 0, 0, 1, c(0,0,0,1,0,0,0,0,0,2'b00,2'b01,2'b01,0,0));
`else
    push(0, 0, 0, 1, c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0));
`endif
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL blt cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    rst_n = 1'b0;
    release_reset();
  endtask

  task automatic test_timeout();
    ctrl_t got, ex;
    stim_t st;
    int cyc = 0;
    // imem never acks: 4 FETCH cycles then TRAP; late ack is ignored
    inst_opcode = 7'b0110011; inst_funct3 = 3'b000;
    repeat (4) push(0, 0, 0, 0, c(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    push(0, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1));
    push(1, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL imem_to cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    rst_n = 1'b0;
    release_reset();
    // Store whose dmem never acks: 4 MEM cycles then TRAP
    cyc = 0;
    inst_opcode = 7'b0100011;
    push_fetch_decode();
    push(0, 0, 0, 0, c(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0,0));
    repeat (4) push(0, 0, 0, 0, c(0,1,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,0));
    push(0, 0, 0, 0, c(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1));
    while (exp_q.size() > 0) begin
      st = stim_q.pop_front(); step(st);
      ex = exp_q.pop_front(); got = sample(); checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL dmem_to cyc=%0d got=%b exp=%b", cyc, got, ex);
      end
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== IDLE) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=%b", got, IDLE);
    end
    release_reset();
  endtask

  initial begin
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump();
    test_async_abort();
    test_illegal();
    test_blt();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
